tile_loader: RTL

TILE_LOADER -- requirements
Module: tile_loader

---
 rtl/tile_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tile_loader.sv
// tile_loader: assembles 16-word rows into a LANE-row tile and hands the
// finished tile downstream over a valid/ready pair.
//
// Ports:
//   clk, reset (async, active-low)
//   in_mode, in_valid, in_ready, in_data[16]   row input stream
//   tile[LANE][16], tile_mode, tile_valid, tile_ready   tile output
// Mode 0 tiles carry one row (row 0), mode 1 tiles carry LANE rows.
// Optional macro TILE_LOADER_PINGPONG_EN adds a second bank so the next
// tile fills while the current one is presented.
module tile_loader #(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int LANE = 128
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_mode,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic signed [15:0][IL+FL-1:0]             in_data,
    output logic signed [LANE-1:0][15:0][IL+FL-1:0]   tile,
    output logic                                      tile_mode,
    output logic                                      tile_valid,
    input  logic                                      tile_ready
);

    localparam int CW = (LANE > 1) ? $clog2(LANE) : 1;

    typedef logic signed [LANE-1:0][15:0][IL+FL-1:0] tile_t;

    logic [CW-1:0] row_cnt_q, row_cnt_d;
    // Holds in_ready low for the first cycle after reset release.
    logic          rdy_en_q, rdy_en_d;
    logic          xfer;
    logic          eff_mode;
    logic          last;

`ifdef TILE_LOADER_PINGPONG_EN

    tile_t      bank_q [2];
    tile_t      bank_d [2];
    logic [1:0] mode_q, mode_d;
    logic       front_q, front_d;
    logic       front_vld_q, front_vld_d;
    logic       back_full_q, back_full_d;
    logic       back;
    logic       consume;
    logic       back_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q[0]   <= '0;
            bank_q[1]   <= '0;
            mode_q      <= '0;
            front_q     <= 1'b0;
            front_vld_q <= 1'b0;
            back_full_q <= 1'b0;
            row_cnt_q   <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            mode_q      <= mode_d;
            front_q     <= front_d;
            front_vld_q <= front_vld_d;
            back_full_q <= back_full_d;
            row_cnt_q   <= row_cnt_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

    always_comb begin
        bank_d      = bank_q;
        mode_d      = mode_q;
        front_d     = front_q;
        front_vld_d = front_vld_q;
        back_full_d = back_full_q;
        row_cnt_d   = row_cnt_q;
        rdy_en_d    = 1'b1;

        back     = ~front_q;
        in_ready = rdy_en_q & ~back_full_q;
        xfer     = in_valid & in_ready;
        // Mode is taken from the stream only on row 0 of a tile.
        eff_mode = (row_cnt_q == '0) ? in_mode : mode_q[back];
        last     = eff_mode ? (row_cnt_q == CW'(LANE - 1))
                            : (row_cnt_q == '0);

        if (xfer) begin
            bank_d[back][row_cnt_q] = in_data;
            if (row_cnt_q == '0) begin
                mode_d[back] = in_mode;
            end
            row_cnt_d = last ? '0 : row_cnt_q + CW'(1);
        end

        consume  = front_vld_q & tile_ready;
        back_rdy = back_full_q | (xfer & last);

        // Swap whenever a complete back bank meets an empty or
        // departing front bank; tile_valid then stays high.
        if (back_rdy && (!front_vld_q || consume)) begin
            front_d     = back;
            front_vld_d = 1'b1;
            back_full_d = 1'b0;
        end else begin
            back_full_d = back_rdy;
            if (consume) begin
                front_vld_d = 1'b0;
            end
        end

        tile       = bank_q[front_q];
        tile_mode  = mode_q[front_q];
        tile_valid = front_vld_q;
    end

`else

    typedef enum logic {FILL, FULL} state_t;

    state_t state_q, state_d;
    tile_t  tile_q, tile_d;
    logic   mode_q, mode_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FILL;
            tile_q    <= '0;
            mode_q    <= 1'b0;
            row_cnt_q <= '0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            mode_q    <= mode_d;
            row_cnt_q <= row_cnt_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        mode_d    = mode_q;
        row_cnt_d = row_cnt_q;
        rdy_en_d  = 1'b1;

        in_ready = rdy_en_q & (state_q == FILL);
        xfer     = in_valid & in_ready;
        // Mode is taken from the stream only on row 0 of a tile.
        eff_mode = (row_cnt_q == '0) ? in_mode : mode_q;
        last     = eff_mode ? (row_cnt_q == CW'(LANE - 1))
                            : (row_cnt_q == '0);

        unique case (1'b1)
            (state_q == FILL): begin
                if (xfer) begin
                    tile_d[row_cnt_q] = in_data;
                    if (row_cnt_q == '0) begin
                        mode_d = in_mode;
                    end
                    if (last) begin
                        row_cnt_d = '0;
                        state_d   = FULL;
                    end else begin
                        row_cnt_d = row_cnt_q + CW'(1);
                    end
                end
            end
            (state_q == FULL): begin
                if (tile_ready) begin
                    state_d = FILL;
                end
            end
            default: ;
        endcase

        tile       = tile_q;
        tile_mode  = mode_q;
        tile_valid = (state_q == FULL);
    end

`endif

endmodule
